// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter for one shared resource.
// Registered one-hot grant, ownership held until release or until MAX_HOLD
// cycles have elapsed, then one turnaround cycle before the next arbitration.
// Arbitration is fixed priority (bit 3 highest). Defining ARB_ROUND_ROBIN_EN
// switches to a round-robin search that starts just after the last owner.
module req_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   hold_cnt_reg;
  logic [1:0]         pick_idx;
  logic               owner_req;
  logic               hold_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]         ptr_reg;

  // Round-robin pick: search ascends from ptr+1 with wrap; the first hit wins.
  // Iterating from the farthest candidate down lets the nearest one overwrite.
  always_comb begin
    pick_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      logic [1:0] cand;
      cand = ptr_reg + 2'(k);
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
  end
`else
  // Fixed-priority pick: highest set bit of req wins.
  always_comb begin
    pick_idx = 2'd0;
    if (req[3])      pick_idx = 2'd3;
    else if (req[2]) pick_idx = 2'd2;
    else if (req[1]) pick_idx = 2'd1;
    else             pick_idx = 2'd0;
  end
`endif

  // Owner still requesting, and hold limit reached on this cycle.
  always_comb begin
    owner_req = req[gnt_idx];
    hold_done = (hold_cnt_reg == CNT_W'(MAX_HOLD));
  end

  // Arbiter state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt          <= 4'b0000;
      gnt_idx      <= 2'b00;
      gnt_valid    <= 1'b0;
      timeout      <= 1'b0;
      hold_cnt_reg <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_reg      <= 2'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg    <= OWN;
            gnt          <= 4'b0001 << pick_idx;
            gnt_idx      <= pick_idx;
            gnt_valid    <= 1'b1;
            hold_cnt_reg <= CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
            ptr_reg      <= pick_idx;
`endif
          end
        end
        OWN: begin
          // Release takes precedence over a simultaneous hold-limit revoke.
          if (!owner_req || hold_done) begin
            state_reg    <= TURN;
            gnt          <= 4'b0000;
            gnt_idx      <= 2'b00;
            gnt_valid    <= 1'b0;
            hold_cnt_reg <= '0;
            timeout      <= owner_req;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
        end
        TURN: begin
          state_reg    <= IDLE;
          hold_cnt_reg <= '0;
        end
        default: begin
          state_reg    <= IDLE;
          gnt          <= 4'b0000;
          gnt_idx      <= 2'b00;
          gnt_valid    <= 1'b0;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter_4.sv
// tb_req_arbiter_4: directed, table-driven bench for req_arbiter_4.
// Each table row is one clock: inputs applied on the falling edge, outputs
// compared 1 time unit after the following rising edge.
module tb_req_arbiter_4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int MH = 1;
`else
  localparam int MH = 3;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors;
  int checks;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  req_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                              input logic [1:0] i, input logic v, input logic t);
    vec_t e;
    e.rst = r; e.req = rq; e.gnt = g; e.idx = i; e.valid = v; e.to = t;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input int vi, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, vi, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int own_cycles;
    bit found;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    req = 4'b0000;

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin, MAX_HOLD=1, all requesting: order 1,2,3,0,1.
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 1);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 1);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 1);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 1);
    add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
    // Reset while owning drops the grant at once; pointer restarts at 0.
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
`else
    // Reset with all requests high, then idle.
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Priority pick of 0110 -> idx 2; release -> TURN, IDLE, then idx 1.
    add(0, 4'b0110, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0010, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0010, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // No pre-emption by req[3]; req[0] drops as the counter hits 3 (no timeout).
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1001, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1001, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1000, 4'b0000, 2'd0, 0, 0);
    // req[3] held: 3 owning cycles, TURN with timeout, IDLE, owner again.
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1000, 4'b0000, 2'd0, 0, 1);
    add(0, 4'b1000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    // Release on the same edge the counter equals 3: release wins.
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Reset mid-grant: grant drops, no turnaround, immediate re-arbitration.
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(1, 4'b0100, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req);
      $display("vec %0d rst=%b req=%b -> gnt=%b idx=%0d valid=%b timeout=%b",
               i, vecs[i].rst, vecs[i].req, gnt, gnt_idx, gnt_valid, timeout);
      chk("gnt",       i, gnt,                 vecs[i].gnt);
      chk("gnt_idx",   i, {2'b00, gnt_idx},    {2'b00, vecs[i].idx});
      chk("gnt_valid", i, {3'b000, gnt_valid}, {3'b000, vecs[i].valid});
      chk("timeout",   i, {3'b000, timeout},   {3'b000, vecs[i].to});
    end

    // Hold-limit sequence: single requester held; count owning cycles until
    // the timeout pulse, bounded so a missing pulse cannot hang the run.
    step(1'b1, 4'b0000);
    own_cycles = 0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step(1'b0, 4'b0100);
      if (timeout) begin
        found = 1'b1;
        chk("timeout_gnt_zero", c, gnt, 4'b0000);
      end else if (gnt_valid) begin
        own_cycles++;
      end
    end
    $display("hold sequence: owning cycles=%0d timeout_seen=%b", own_cycles, found);
    chk("timeout_seen", 0, {3'b000, found}, 4'b0001);
    chk("hold_cycles", 0, own_cycles[3:0], 4'(MH));
    step(1'b0, 4'b0100);
    chk("timeout_width", 0, {3'b000, timeout}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
